// File: rtl/output_writeback.sv
`timescale 1ns/1ps
// Captures one systolic tile of results and drains the valid entries as single-word buffer writes.
// Build option: define OUTPUT_WB_RELU_EN to clamp negative results to zero at capture.
module output_writeback #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int MAX_N  = 512,
    parameter int N_BITS = $clog2(MAX_N + 1),
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                stall,
    input  logic [ROWS*COLS-1:0]                in_valid,
    input  logic [ROWS*COLS-1:0][N_BITS-1:0]    in_row,
    input  logic [ROWS*COLS-1:0][N_BITS-1:0]    in_col,
    input  logic [ROWS*COLS-1:0][DATA_W-1:0]    in_data,
    input  logic [N_BITS-1:0]                   mat_cols,
    input  logic [ADDR_W-1:0]                   base_addr,
    output logic                                capture_ready,
    output logic                                wr_en,
    output logic [ADDR_W-1:0]                   wr_addr,
    output logic [DATA_W-1:0]                   wr_data,
    input  logic                                wr_ready,
    output logic                                busy,
    output logic                                overflow_err
);

    localparam int NUM    = ROWS * COLS;
    localparam int IDX_W  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int PROD_W = 2 * N_BITS;
    localparam int SUM_W  = ((PROD_W > ADDR_W) ? PROD_W : ADDR_W) + 2;

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [NUM-1:0]               r_pending;
    logic [NUM-1:0]               w_pending_nxt;
    logic [NUM-1:0][ADDR_W-1:0]   r_addr;
    logic [NUM-1:0][DATA_W-1:0]   r_data;
    logic [NUM-1:0][ADDR_W-1:0]   w_addr;
    logic [NUM-1:0][DATA_W-1:0]   w_data;
    logic                         r_overflow;
    logic [IDX_W-1:0]             w_sel;
    logic [NUM-1:0]               w_sel_oh;
    logic                         w_tile_in;
    logic                         w_retire;
    logic                         w_last;
    logic                         w_accept;
    logic                         w_drop;

    // Full-width product so large coordinates wrap only at the final truncation.
    function automatic logic [ADDR_W-1:0] flat_addr(
        input logic [ADDR_W-1:0] base,
        input logic [N_BITS-1:0] stride,
        input logic [N_BITS-1:0] row,
        input logic [N_BITS-1:0] col
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(base) + SUM_W'(row) * SUM_W'(stride) + SUM_W'(col);
        return s[ADDR_W-1:0];
    endfunction

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NUM; i++) begin
            w_addr[i] = flat_addr(base_addr, mat_cols, in_row[i], in_col[i]);
`ifdef OUTPUT_WB_RELU_EN
            w_data[i] = in_data[i][DATA_W-1] ? '0 : in_data[i];
`else
            w_data[i] = in_data[i];
`endif
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = IDX_W'(i);
            end
        end
        w_sel_oh = NUM'(1) << w_sel;
    end

    assign busy          = (r_state == S_DRAIN);
    assign wr_en         = busy && !stall;
    assign w_retire      = wr_en && wr_ready;
    assign w_last        = w_retire && ((r_pending & ~w_sel_oh) == '0);
    assign capture_ready = !busy || w_last;
    assign w_tile_in     = (|in_valid) && !stall;
    assign w_accept      = w_tile_in && capture_ready;
    assign w_drop        = w_tile_in && !capture_ready;
    assign wr_addr       = busy ? r_addr[w_sel] : '0;
    assign wr_data       = busy ? r_data[w_sel] : '0;
    assign overflow_err  = r_overflow;

    // A capture only happens when nothing else stays pending, so it replaces the mask.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_accept) begin
            w_pending_nxt = in_valid;
        end else if (w_retire) begin
            w_pending_nxt = r_pending & ~w_sel_oh;
        end
        w_state_nxt = (|w_pending_nxt) ? S_DRAIN : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= w_addr;
            r_data <= w_data;
        end
    end

endmodule

// File: tb/tb_output_writeback.sv
`timescale 1ns/1ps
// Scoreboard bench for output_writeback: stimulus queues expected writes, a monitor checks them.
// Expected clamp behaviour follows OUTPUT_WB_RELU_EN when it is defined for the build.
module tb_output_writeback;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int NUM    = ROWS * COLS;
    localparam int N_BITS = 10;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 18;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } exp_t;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             stall;
    logic [NUM-1:0]                   in_valid;
    logic [NUM-1:0][N_BITS-1:0]       in_row;
    logic [NUM-1:0][N_BITS-1:0]       in_col;
    logic [NUM-1:0][DATA_W-1:0]       in_data;
    logic [N_BITS-1:0]                mat_cols;
    logic [ADDR_W-1:0]                base_addr;
    logic                             capture_ready;
    logic                             wr_en;
    logic [ADDR_W-1:0]                wr_addr;
    logic [DATA_W-1:0]                wr_data;
    logic                             wr_ready;
    logic                             busy;
    logic                             overflow_err;

    exp_t exp_q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    output_writeback dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .in_valid      (in_valid),
        .in_row        (in_row),
        .in_col        (in_col),
        .in_data       (in_data),
        .mat_cols      (mat_cols),
        .base_addr     (base_addr),
        .capture_ready (capture_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .busy          (busy),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1 && wr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                         wr_addr, wr_data);
            end else begin
                m_e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(m_e.a));
                chk("wr_data", 64'(wr_data), 64'(m_e.d));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tile(input logic [NUM-1:0] mask, input int base, input int mc,
                              input int r0, input int c0, input int d0, input int dstep,
                              input bit push);
        exp_t e;
        int   a;
        int   d;
        base_addr = ADDR_W'(base);
        mat_cols  = N_BITS'(mc);
        for (int i = 0; i < NUM; i++) begin
            d           = d0 + i * dstep;
            in_valid[i] = mask[i];
            in_row[i]   = N_BITS'(r0 + i / COLS);
            in_col[i]   = N_BITS'(c0 + i % COLS);
            in_data[i]  = DATA_W'(d);
            if (push && mask[i]) begin
                a = base + (r0 + i / COLS) * mc + (c0 + i % COLS);
`ifdef OUTPUT_WB_RELU_EN
                if (d < 0) d = 0;
`endif
                e.a = ADDR_W'(a);
                e.d = DATA_W'(d);
                exp_q.push_back(e);
            end
        end
    endtask

    // Called at a falling edge; counts busy cycles until the drain ends.
    task automatic drain(input string name, input int exp_n);
        int n = 0;
        bit done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            if (busy !== 1'b1) begin
                done = 1'b1;
            end else begin
                n++;
                step();
                @(negedge clk);
            end
        end
        chk(name, 64'(n), 64'(exp_n));
        chk({name, "_q"}, 64'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        stall     = 1'b0;
        in_valid  = '0;
        in_row    = '0;
        in_col    = '0;
        in_data   = '0;
        mat_cols  = '0;
        base_addr = '0;
        wr_ready  = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_wr_en", 64'(wr_en), 0);
        chk("rst_cap_rdy", 64'(capture_ready), 1);
        chk("rst_ovf", 64'(overflow_err), 0);
        chk("rst_addr", 64'(wr_addr), 0);
        chk("rst_data", 64'(wr_data), 0);
        step();
        reset = 1'b1;

        // full tile
        drive_tile(16'hFFFF, 100, 8, 4, 2, 10, 7, 1'b1);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("full_first_en", 64'(wr_en), 1);
        chk("full_first_addr", 64'(wr_addr), 134);
        drain("full_len", 16);

        // sparse tile
        drive_tile(16'h1008, 100, 8, 4, 2, -20, 3, 1'b1);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("sparse_rdy0", 64'(capture_ready), 0);
        chk("sparse_addr0", 64'(wr_addr), 137);
        step();
        @(negedge clk);
        chk("sparse_rdy_last", 64'(capture_ready), 1);
        chk("sparse_addr1", 64'(wr_addr), 158);
        step();
        @(negedge clk);
        chk("sparse_idle", 64'(busy), 0);

        // stall while idle with a tile presented
        stall = 1'b1;
        drive_tile(16'h0001, 50, 2, 0, 0, 77, 0, 1'b1);
        step();
        step();
        @(negedge clk);
        chk("stall_nocap", 64'(busy), 0);
        chk("stall_ovf", 64'(overflow_err), 0);
        step();
        stall = 1'b0;
        step();
        in_valid = '0;
        @(negedge clk);
        chk("stall_cap", 64'(busy), 1);
        drain("stall_len", 1);

        // backpressure and stall mid-drain
        drive_tile(16'hFFFF, 200, 16, 1, 0, 1000, 3, 1'b1);
        step();
        in_valid = '0;
        repeat (4) step();
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_en", 64'(wr_en), 1);
            chk("bp_addr", 64'(wr_addr), 232);
            chk("bp_data", 64'(wr_data), 1012);
            step();
        end
        wr_ready = 1'b1;
        step();
        step();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stl_en", 64'(wr_en), 0);
            chk("stl_busy", 64'(busy), 1);
            chk("stl_addr", 64'(wr_addr), 234);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        drain("bp_len", 10);

        // overflow while 5 entries pending
        drive_tile(16'h001F, 0, 4, 0, 0, 5, 1, 1'b1);
        step();
        in_valid = '0;
        wr_ready = 1'b0;
        drive_tile(16'hFFFF, 300, 4, 0, 0, 0, 1, 1'b0);
        @(negedge clk);
        chk("ovf_rdy", 64'(capture_ready), 0);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("ovf_pulse", 64'(overflow_err), 1);
        chk("ovf_busy", 64'(busy), 1);
        step();
        @(negedge clk);
        chk("ovf_clear", 64'(overflow_err), 0);
        step();
        wr_ready = 1'b1;
        @(negedge clk);
        drain("ovf_len", 5);

        // back-to-back tiles
        drive_tile(16'h0003, 10, 4, 0, 0, 1, 1, 1'b1);
        step();
        in_valid = '0;
        step();
        drive_tile(16'h0030, 20, 4, 0, 0, 50, 1, 1'b1);
        @(negedge clk);
        chk("b2b_rdy", 64'(capture_ready), 1);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("b2b_busy", 64'(busy), 1);
        chk("b2b_en", 64'(wr_en), 1);
        chk("b2b_addr", 64'(wr_addr), 24);
        drain("b2b_len", 2);

        // reset in the middle of a drain
        drive_tile(16'hFFFF, 0, 8, 0, 0, 0, 1, 1'b1);
        step();
        in_valid = '0;
        repeat (7) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mrst_busy", 64'(busy), 0);
        chk("mrst_wr_en", 64'(wr_en), 0);
        chk("mrst_cap_rdy", 64'(capture_ready), 1);
        step();
        drive_tile(16'hFFFF, 1000, 10, 3, 3, -100, 9, 1'b1);
        step();
        in_valid = '0;
        @(negedge clk);
        drain("mrst_new_len", 16);

        // data clamp
        step();
        drive_tile(16'h0003, 7, 3, 0, 0, -5, 14, 1'b1);
        step();
        in_valid = '0;
        @(negedge clk);
`ifdef OUTPUT_WB_RELU_EN
        chk("clamp_neg", 64'(wr_data), 0);
`else
        chk("clamp_neg", 64'(wr_data), 64'(32'hFFFF_FFFB));
`endif
        drain("clamp_len", 2);

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
